sample_pacer: RTL and testbench



---
 rtl/sample_pacer.sv | 123 ++++++++++++
 tb/tb_sample_pacer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_pacer.sv
// sample_pacer: FIFO-side audio pacer. Waits for a prefill level, pops one
// sample per CLK_DIV clocks, scales it by volume and strobes it out to the
// PWM stage. An empty FIFO at a tick holds the last sample, counts an
// underrun and drops back to prefill so the reader can catch up.
module sample_pacer #(
    parameter int CLK_DIV = 2268,
    parameter int PREFILL = 512,
    parameter int CW      = 11
) (
    input  logic          clk_100mhz,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [CW-1:0] fifo_count,
    input  logic          fifo_empty,
    input  logic [7:0]    fifo_dout,
    output logic          fifo_rd_en,
    input  logic [3:0]    volume,
    output logic [7:0]    sample_out,
    output logic          sample_valid,
    output logic          underrun,
    output logic [15:0]   underrun_count,
    output logic          playing
);

    localparam int              TW          = $clog2(CLK_DIV);
    localparam logic [TW-1:0]   TICK_AT     = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   PREFILL_LVL = CW'(PREFILL);
    localparam int              STAGES      = 1;

    typedef enum logic [1:0] {IDLE, PRE, PLAY} state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [STAGES:0] vld_pipe;   // a tick is in flight (pop or underrun)
    logic [STAGES:0] pop_pipe;   // that tick actually popped the FIFO
    logic [1:0]      rst_sync;
    logic            rst_n;
    logic            tick;

    // Centred gain: (s-128)*vol/16 + 128, floor shift; vol 15 is bypass.
    function automatic logic [7:0] scale(input logic [7:0] s, input logic [3:0] v);
        logic signed [8:0]  d;
        logic signed [12:0] p;
        logic signed [12:0] q;
        d = $signed({1'b0, s}) - 9'sd128;
        p = $signed({{4{d[8]}}, d}) * $signed({9'b0, v});
        q = p >>> 4;
        if (v == 4'hF) scale = s;
        else           scale = 8'(q + 13'sd128);
    endfunction

    // Reset asserts immediately, releases two clocks after reset_n rises.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign tick = (state == PLAY) && (tick_cnt == TICK_AT);

    // Control FSM, sample period counter, read pipeline and outputs.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            vld_pipe       <= '0;
            pop_pipe       <= '0;
            fifo_rd_en     <= 1'b0;
            sample_out     <= 8'h80;
            sample_valid   <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= 16'h0000;
            playing        <= 1'b0;
        end else if (!enable) begin
            // Stop/mute: flush in-flight samples, output silence.
            state        <= IDLE;
            tick_cnt     <= '0;
            vld_pipe     <= '0;
            pop_pipe     <= '0;
            fifo_rd_en   <= 1'b0;
            sample_out   <= 8'h80;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            playing      <= 1'b0;
        end else begin
            fifo_rd_en   <= 1'b0;
            underrun     <= 1'b0;
            vld_pipe     <= {vld_pipe[STAGES-1:0], tick};
            pop_pipe     <= {pop_pipe[STAGES-1:0], tick && !fifo_empty};
            sample_valid <= vld_pipe[STAGES];
            // fifo_dout is valid here, one cycle after the pop
            if (vld_pipe[STAGES] && pop_pipe[STAGES])
                sample_out <= scale(fifo_dout, volume);

            case (state)
                IDLE: state <= PRE;
                PRE: begin
                    if (fifo_count >= PREFILL_LVL) begin
                        state    <= PLAY;
                        playing  <= 1'b1;
                        tick_cnt <= '0;
                    end
                end
                PLAY: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) begin
                        if (!fifo_empty) begin
                            fifo_rd_en <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
                            if (underrun_count != 16'hFFFF)
                                underrun_count <= underrun_count + 16'd1;
                            state   <= PRE;
                            playing <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// tb_sample_pacer: directed bench for sample_pacer with CLK_DIV=8, PREFILL=4
// and a small standard-mode FIFO model feeding it.
module tb_sample_pacer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [10:0] fifo_count;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en;
    logic [3:0]  volume;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        underrun;
    logic [15:0] underrun_count;
    logic        playing;

    sample_pacer #(.CLK_DIV(8), .PREFILL(4), .CW(11)) dut (
        .clk_100mhz    (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .fifo_count    (fifo_count),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .volume        (volume),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .underrun      (underrun),
        .underrun_count(underrun_count),
        .playing       (playing)
    );

    always #5 clk = ~clk;

    // FIFO model: writes from the stimulus, reads on fifo_rd_en, data next cycle
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_count = 11'(wr_ptr - rd_ptr);
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && rd_ptr < wr_ptr) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Event log sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int rd_cnt = 0, ur_cnt = 0, rd_bad = 0;
    int last_rd = -100, last_ur = -100;
    logic [7:0] sv_q[$];
    int sv_t[$];
    int sv_lat[$];
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt++;
            last_rd = cyc;
            if (!playing) rd_bad++;
        end
        if (underrun) begin
            ur_cnt++;
            last_ur = cyc;
        end
        if (sample_valid) begin
            sv_q.push_back(sample_out);
            sv_t.push_back(cyc);
            sv_lat.push_back(cyc - ((last_rd > last_ur) ? last_rd : last_ur));
        end
    end

    int checks = 0;
    int errors = 0;
    int sv_rd  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Next strobe must carry exp, 3 cycles after its tick (2 after pop/underrun)
    task automatic expect_sv(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (sv_q.size() <= sv_rd && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (sv_q.size() <= sv_rd) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk(tag, 32'(sv_q[sv_rd]), 32'(exp));
            chk({tag, "_lat"}, sv_lat[sv_rd], 32'd2);
            sv_rd++;
        end
    endtask

    task automatic wait_rd(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!fifo_rd_en && n < 30);
        if (!fifo_rd_en) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int p, n, u0;
        reset_n = 1'b0;
        enable  = 1'b0;
        volume  = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_out",   32'(sample_out), 32'h80);
        chk("rst_rd",    32'(fifo_rd_en), 32'd0);
        chk("rst_sv",    32'(sample_valid), 32'd0);
        chk("rst_ur",    32'(underrun), 32'd0);
        chk("rst_cnt",   32'(underrun_count), 32'd0);
        chk("rst_play",  32'(playing), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // prefill below threshold holds off playback
        push(8'hFF); push(8'h00); push(8'h80);
        enable = 1'b1;
        repeat (12) @(negedge clk);
        chk("prefill_hold", 32'(playing), 32'd0);
        chk("prefill_no_rd", rd_cnt, 32'd0);

        push(8'hFF); push(8'h00); push(8'hFF); push(8'h00); push(8'h5A);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!playing && n < 10);
        chk("play_start", 32'(playing), 32'd1);
        p = cyc;
        wait_rd("first_rd");
        chk("first_rd_delay", cyc - p, 32'd8);

        // unity gain, period spacing
        expect_sv("u_ff", 8'hFF);
        expect_sv("u_00", 8'h00);
        expect_sv("u_80", 8'h80);
        chk("period0", sv_t[1] - sv_t[0], 32'd8);
        chk("period1", sv_t[2] - sv_t[1], 32'd8);
        volume = 4'd8;
        expect_sv("v8_ff", 8'hBF);
        expect_sv("v8_00", 8'h40);
        volume = 4'd0;
        expect_sv("v0_ff", 8'h80);
        expect_sv("v0_00", 8'h80);
        volume = 4'hF;
        expect_sv("s_5a", 8'h5A);

        // FIFO now empty: next tick underruns
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!underrun && n < 20);
        chk("ur_pulse", 32'(underrun), 32'd1);
        chk("ur_cnt1", 32'(underrun_count), 32'd1);
        chk("ur_play", 32'(playing), 32'd0);
        chk("ur_no_rd", rd_cnt, 32'd8);
        expect_sv("ur_hold", 8'h5A);
        repeat (4) @(negedge clk);
        chk("ur_prefill", 32'(playing), 32'd0);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_sv("resume", 8'h11);

        // drop enable the cycle after a pop
        wait_rd("drop_rd");
        chk("pre_drop", 32'(sample_out), 32'h11);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk); #1;
        chk("drop_mute", 32'(sample_out), 32'h80);
        chk("drop_sv", 32'(sample_valid), 32'd0);
        chk("drop_play", 32'(playing), 32'd0);
        repeat (6) @(negedge clk);
        chk("drop_no_sv", sv_q.size(), sv_rd);

        // re-enable, count survives, then async reset mid-period
        enable = 1'b1;
        push(8'h55); push(8'h66);
        expect_sv("reen", 8'h33);
        chk("cnt_kept", 32'(underrun_count), 32'd1);
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_play", 32'(playing), 32'd0);
        chk("arst_out",  32'(sample_out), 32'h80);
        chk("arst_cnt",  32'(underrun_count), 32'd0);
        chk("arst_rd",   32'(fifo_rd_en), 32'd0);
        chk("arst_sv",   32'(sample_valid), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // saturation
        force dut.underrun_count = 16'hFFFF;
        @(negedge clk);
        release dut.underrun_count;
        @(negedge clk); #1;
        chk("forced", 32'(underrun_count), 32'hFFFF);
        push(8'h77);
        u0 = ur_cnt;
        enable = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!underrun && n < 120);
        chk("sat_pulse", ur_cnt - u0, 32'd1);
        chk("sat_cnt", 32'(underrun_count), 32'hFFFF);
        chk("rd_in_play", rd_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
